// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between fixed-latency video reads and posted CPU byte writes.
module vram_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int AW = 13
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic                        cpu_we,
   input  logic [15:0]                 cpu_addr,
   input  logic [7:0]                  cpu_din,
   output logic                        cpu_ready,
   input  logic                        vid_req,
   input  logic [AW-1:0]               vid_addr,
   output logic [31:0]                 vid_data,
   output logic                        vid_valid,
   output logic [AW-1:0]               mem_addr,
   output logic                        mem_we,
   output logic [3:0]                  mem_be,
   output logic [31:0]                 mem_wdata,
   input  logic [31:0]                 mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   logic [22:0]   fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          rd_p1, rd_p2, push_req, pop, push;
   logic [22:0]   head;
   logic [LW-1:0] level_nxt;
   always_comb begin
      push_req  = cpu_we && cpu_addr[15];
      pop       = !vid_req && fifo_level != '0;
      push      = push_req && (fifo_level != LW'(FIFO_DEPTH) || pop);
      head      = fifo[rd_ptr];
      level_nxt = fifo_level + LW'(push) - LW'(pop);
   end
   // Entry layout: {word[12:0], lane[1:0], data[7:0]}
   always_ff @(posedge clk_sys)
      if (push) fifo[wr_ptr] <= {cpu_addr[12:0], cpu_addr[14:13], cpu_din};
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cpu_ready  <= 1'b1;
         overflow   <= 1'b0;
         rd_p1      <= 1'b0;
         rd_p2      <= 1'b0;
         vid_valid  <= 1'b0;
         vid_data   <= '0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         rd_p1      <= vid_req;
         rd_p2      <= rd_p1;
         vid_valid  <= rd_p2;
         if (rd_p2) vid_data <= mem_rdata;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         overflow   <= overflow | (push_req & !push);
         fifo_level <= level_nxt;
         cpu_ready  <= level_nxt != LW'(FIFO_DEPTH);
         mem_we     <= pop;
         mem_be     <= pop ? 4'b0001 << head[9:8] : 4'b0000;
         if (vid_req) mem_addr <= vid_addr;
         else if (pop) begin
            mem_addr  <= AW'(head[22:10]);
            mem_wdata <= {4{head[7:0]}};
         end
      end
   end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, 32-bit-wide video RAM between two requesters: the video fetch, which reads 4 bit-planes per word, and CPU byte writes to the 0x8000-0xFFFF window.
- Video reads always win and have a fixed latency.
- CPU writes are posted into a small FIFO and drained in cycles when no video read is issued.
- Sits between the CPU bus / video timing logic and the VRAM macro. This replaces the dual-port shadow RAM.

Parameters:
- FIFO_DEPTH, 4: number of posted CPU writes held. Must be a power of two, 2..16.
- AW, 13: VRAM word-address width.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_we  in  1  CPU write strobe, one clk_sys cycle per write
- cpu_addr  in  16  CPU address. bit15 = VRAM window, [14:13] = plane/byte lane, [12:0] = word
- cpu_din  in  8  CPU write data
- cpu_ready  out  1  FIFO not full
- vid_req  in  1  video fetch request, one-cycle pulse
- vid_addr  in  AW  word address to read
- vid_data  out  32  fetched word, {plane3, plane2, plane1, plane0}
- vid_valid  out  1  vid_data valid, one-cycle pulse
- mem_addr  out  AW  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_be  out  4  RAM byte enables, registered
- mem_wdata  out  32  RAM write data (byte replicated on all lanes), registered
- mem_rdata  in  32  RAM read data, valid one cycle after the address is presented
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset values: cpu_ready=1, vid_valid=0, vid_data=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, fifo_level=0, overflow=0.
- Reset mid-operation flushes the FIFO and cancels any in-flight read: no vid_valid from a read issued before reset.
- CPU push:
  - On cpu_we=1 with cpu_addr[15]=1, push {addr[12:0], addr[14:13], din}.
  - cpu_addr[15]=0 is ignored. It does not push and does not set overflow.
  - Push while full (after accounting for a pop in the same cycle) is dropped and sets overflow.
  - Push and pop in the same cycle at full is accepted; fifo_level is unchanged.
- Per-edge port schedule, in priority order:
  1. vid_req=1 -> mem_addr<=vid_addr, mem_we<=0, mem_be<=0.
  2. Else FIFO not empty -> pop the head; mem_addr<=word, mem_be<=one-hot(lane), mem_wdata<={4{din}}, mem_we<=1.
  3. Else -> mem_we<=0, mem_be<=0, mem_addr holds.
- Read latency:
  - Let vid_req be sampled at edge E0. The RAM samples the address at E1, and the arbiter captures mem_rdata into vid_data at E2.
  - vid_valid=1 for exactly the one cycle after E2.
  - Latency is always 2 edges, independent of write traffic.
  - Back-to-back vid_req is supported; each request produces its own pulse, in order.
- vid_data holds its value between pulses.
- Write drain: a FIFO entry issues in the first edge with vid_req=0. If vid_req is held continuously, writes stall, the FIFO fills and cpu_ready drops.
- cpu_ready = (fifo_level != FIFO_DEPTH), registered and consistent with fifo_level after each edge.
- Ordering: writes reach RAM in push order.
- Same-edge collision: a vid_req issued on the same edge a write is pushed, or while older writes are queued, returns pre-write data. This is accepted behaviour; software-visible effects are limited to one fetch.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH.

Test Plan:
- Reset then idle 10 cycles -> all outputs at reset values; mem_we never asserts.
- cpu_we with addr=0xA005, din=0x5A, no vid_req -> next edge: mem_addr=0x0005, mem_be=4'b0010, mem_wdata=0x5A5A5A5A, mem_we=1 for one cycle; fifo_level returns to 0.
- Preload RAM word 0x0123 = 0xDEADBEEF; vid_req with vid_addr=0x0123 -> vid_valid exactly 2 edges later, vid_data=0xDEADBEEF. Repeat with the FIFO holding 3 writes -> same latency.
- Hold vid_req high 8 cycles while issuing 5 CPU writes (FIFO_DEPTH=4):
  - cpu_ready drops after the 4th write.
  - The 5th write is dropped and overflow=1.
  - After vid_req drops, 4 writes drain in 4 consecutive cycles, in push order.
- cpu_we with addr=0x4005 -> no push, fifo_level=0, overflow=0.
- Assert reset with 2 writes queued and a read in flight -> no mem_we, no vid_valid afterwards; fifo_level=0.
